// File: rtl/btb_if.sv
// Fetch-lookup and execute-resolution bus of the branch target buffer.
//   master: fetch/execute side; drives fetch_pc and the resolution fields, reads the prediction.
//   slave : the BTB; returns hit / predicted_taken / predicted_target.
interface btb_if;
  logic [31:0] fetch_pc;
  logic        predicted_taken;
  logic [31:0] predicted_target;
  logic        hit;
  logic        update_btb;
  logic [31:0] update_pc;
  logic [31:0] calc_jump_addr;
  logic        update_taken;
  logic        btb_flush;

  modport master (
    output fetch_pc, update_btb, update_pc, calc_jump_addr, update_taken, btb_flush,
    input  predicted_taken, predicted_target, hit
  );

  modport slave (
    input  fetch_pc, update_btb, update_pc, calc_jump_addr, update_taken, btb_flush,
    output predicted_taken, predicted_target, hit
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk - clock, all state changes on the rising edge
//   rst - synchronous active-high reset
//   bus - btb_if.slave: same-cycle lookup of fetch_pc, plus the execute-stage
//         resolution (update_btb/update_pc/calc_jump_addr/update_taken) and btb_flush
// Build option: define BTB_FWD_EN to forward a same-cycle update to a lookup of the
// same index; otherwise lookups always read registered contents.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16
) (
  input logic  clk,
  input logic  rst,
  btb_if.slave bus
);
  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - IDX;

  // Encoding is shared with the rest of the pipeline; note taken states are 1x.
  typedef enum logic [1:0] {
    StStrongNt = 2'b00,
    StWeakNt   = 2'b01,
    StStrongT  = 2'b10,
    StWeakT    = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(ctr_e cur, logic taken);
    ctr_e nxt;
    unique case (cur)
      StStrongNt: nxt = taken ? StWeakNt   : StStrongNt;
      StWeakNt:   nxt = taken ? StWeakT    : StStrongNt;
      StWeakT:    nxt = taken ? StStrongT  : StWeakNt;
      StStrongT:  nxt = taken ? StStrongT  : StWeakT;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q    [ENTRIES];
  logic [TagW-1:0]    tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  ctr_e               state_q  [ENTRIES];
  ctr_e               state_d  [ENTRIES];

  logic [IDX-1:0]  f_idx, u_idx;
  logic [TagW-1:0] f_tag, u_tag;
  logic            upd_hit;

  assign f_idx = bus.fetch_pc[IDX+1:2];
  assign f_tag = bus.fetch_pc[31:IDX+2];
  assign u_idx = bus.update_pc[IDX+1:2];
  assign u_tag = bus.update_pc[31:IDX+2];

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

  assign upd_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    state_d  = state_q;
    if (bus.btb_flush) begin
      // Flush wins; a coincident update is dropped.
      valid_d = '0;
    end else if (bus.update_btb) begin
      if (upd_hit) begin
        state_d[u_idx] = ctr_next(state_q[u_idx], bus.update_taken);
        if (bus.update_taken) target_d[u_idx] = bus.calc_jump_addr;
      end else if (bus.update_taken) begin
        // Only taken branches allocate; a not-taken miss is not worth an entry.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bus.calc_jump_addr;
        state_d[u_idx]  = StWeakT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      state_q  <= '{default: StWeakNt};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      state_q  <= state_d;
    end
  end

  // Lookup read port.
  logic            rd_valid;
  logic [TagW-1:0] rd_tag;
  logic [31:0]     rd_target;
  ctr_e            rd_state;

`ifdef BTB_FWD_EN
  logic fwd;
  assign fwd = bus.update_btb && (f_idx == u_idx);

  always_comb begin
    rd_valid  = valid_q[f_idx];
    rd_tag    = tag_q[f_idx];
    rd_target = target_q[f_idx];
    rd_state  = state_q[f_idx];
    if (fwd) begin
      if (bus.btb_flush || rst) begin
        rd_valid = 1'b0;
      end else begin
        rd_valid  = valid_d[f_idx];
        rd_tag    = tag_d[f_idx];
        rd_target = target_d[f_idx];
        rd_state  = state_d[f_idx];
      end
    end
  end
`else
  always_comb begin
    rd_valid  = valid_q[f_idx];
    rd_tag    = tag_q[f_idx];
    rd_target = target_q[f_idx];
    rd_state  = state_q[f_idx];
  end
`endif

  always_comb begin
    bus.hit              = rd_valid && (rd_tag == f_tag);
    bus.predicted_taken  = bus.hit && rd_state[1];
    bus.predicted_target = bus.hit ? rd_target : 32'h0;
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  btb_if bus ();

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lookup(input string tag, input logic [31:0] pc, input logic e_hit,
                               input logic e_pt, input logic [31:0] e_tgt);
    bus.fetch_pc = pc;
    #1;
    check_eq({tag, ".hit"}, {31'b0, bus.hit}, {31'b0, e_hit});
    check_eq({tag, ".pt"}, {31'b0, bus.predicted_taken}, {31'b0, e_pt});
    check_eq({tag, ".tgt"}, bus.predicted_target, e_tgt);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    bus.update_btb     = 1'b1;
    bus.update_pc      = pc;
    bus.calc_jump_addr = tgt;
    bus.update_taken   = taken;
    tick();
    bus.update_btb     = 1'b0;
  endtask

  initial begin
    bus.fetch_pc       = 32'h0;
    bus.update_btb     = 1'b0;
    bus.update_pc      = 32'h0;
    bus.calc_jump_addr = 32'h0;
    bus.update_taken   = 1'b0;
    bus.btb_flush      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    expect_lookup("reset", 32'h100, 1'b0, 1'b0, 32'h0);

    do_update(32'h100, 32'h200, 1'b1);               // allocate WT
    expect_lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 32'h999, 1'b0);               // WNT, target kept
    expect_lookup("wnt", 32'h100, 1'b1, 1'b0, 32'h200);
    do_update(32'h100, 32'h999, 1'b0);               // SNT
    expect_lookup("snt", 32'h100, 1'b1, 1'b0, 32'h200);
    do_update(32'h100, 32'h200, 1'b1);               // WNT
    expect_lookup("snt_t", 32'h100, 1'b1, 1'b0, 32'h200);
    do_update(32'h100, 32'h200, 1'b1);               // WT
    expect_lookup("wnt_t", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 32'h200, 1'b1);               // ST
    do_update(32'h100, 32'h200, 1'b1);               // ST saturates
    do_update(32'h100, 32'h999, 1'b0);               // WT
    expect_lookup("st_nt", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 32'h999, 1'b0);               // WNT: proves ST saturated
    expect_lookup("sat", 32'h100, 1'b1, 1'b0, 32'h200);
    do_update(32'h100, 32'h200, 1'b1);               // back to WT

    // Aliasing: 0x140 shares index 0 with tag 5 vs 4.
    expect_lookup("alias_miss", 32'h140, 1'b0, 1'b0, 32'h0);
    do_update(32'h140, 32'h300, 1'b0);
    expect_lookup("alias_keep", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h140, 32'h300, 1'b1);
    expect_lookup("alias_evict", 32'h100, 1'b0, 1'b0, 32'h0);
    expect_lookup("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

    // Other index, low PC bits ignored.
    expect_lookup("idx1_miss", 32'h104, 1'b0, 1'b0, 32'h0);
    do_update(32'h107, 32'h880, 1'b1);
    expect_lookup("idx1_hit", 32'h104, 1'b1, 1'b1, 32'h880);
    expect_lookup("idx0_intact", 32'h140, 1'b1, 1'b1, 32'h300);

    // Rebuild 0x100 as SNT with target 0x200.
    do_update(32'h100, 32'h200, 1'b1);
    do_update(32'h100, 32'h0, 1'b0);
    do_update(32'h100, 32'h0, 1'b0);
    expect_lookup("snt2", 32'h100, 1'b1, 1'b0, 32'h200);

    // Same-cycle update and lookup on the same index.
    bus.fetch_pc       = 32'h100;
    bus.update_btb     = 1'b1;
    bus.update_pc      = 32'h100;
    bus.calc_jump_addr = 32'h400;
    bus.update_taken   = 1'b1;
`ifdef BTB_FWD_EN
    expect_lookup("same_cyc", 32'h100, 1'b1, 1'b0, 32'h400);
`else
    expect_lookup("same_cyc", 32'h100, 1'b1, 1'b0, 32'h200);
`endif
    tick();
    bus.update_btb = 1'b0;
    expect_lookup("after_same", 32'h100, 1'b1, 1'b0, 32'h400);

    // Flush with a coincident taken update: update dropped.
    bus.btb_flush = 1'b1;
    do_update(32'h100, 32'h500, 1'b1);
    bus.btb_flush = 1'b0;
    expect_lookup("flush", 32'h100, 1'b0, 1'b0, 32'h0);
    expect_lookup("flush_idx1", 32'h104, 1'b0, 1'b0, 32'h0);

    // Reset mid-operation beats a concurrent update.
    do_update(32'h100, 32'h600, 1'b1);
    expect_lookup("pre_rst", 32'h100, 1'b1, 1'b1, 32'h600);
    rst = 1'b1;
    do_update(32'h100, 32'h700, 1'b1);
    rst = 1'b0;
    expect_lookup("mid_rst", 32'h100, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
